// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit-select mux among 8 requesters.
// Grants are held for up to BURST accepted beats or until the owner withdraws.
module mux_rr_arbiter #(
    parameter int NREQ  = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          data_in,
    input  logic                     ready,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  sel,
    output logic                     valid,
    output logic                     y,
    output logic                     last,
    output logic                     busy,
    output logic                     o_dbg_state,
    output logic [$clog2(NREQ)-1:0]  o_dbg_ptr,
    output logic [2:0]               o_dbg_cnt
);

    localparam int SW = $clog2(NREQ);
    localparam logic [2:0] LAST_CNT = 3'(BURST - 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    // Handshake: a beat transfers on a rising edge where valid && ready are
    // both high; valid never depends on ready, and ready may depend on valid.

    state_t          r_state, w_state_nx;
    logic [SW-1:0]   r_sel, w_sel_nx;
    logic [SW-1:0]   r_ptr, w_ptr_nx;
    logic [NREQ-1:0] r_grant, w_grant_nx;
    logic [2:0]      r_cnt, w_cnt_nx;
    logic [SW-1:0]   w_pick;
    logic            w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_grant <= w_grant_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Walk from the far end back toward ptr so the closest requester wins.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[r_ptr + SW'(k)]) begin
                w_pick  = r_ptr + SW'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        w_grant_nx = r_grant;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_BUSY;
                    w_sel_nx   = w_pick;
                    w_grant_nx = NREQ'(1) << w_pick;
                    w_cnt_nx   = '0;
                end
            end
            S_BUSY: begin
                if (!req[r_sel] || (ready && r_cnt == LAST_CNT)) begin
                    w_state_nx = S_IDLE;
                    w_grant_nx = '0;
                    w_cnt_nx   = '0;
                    w_ptr_nx   = r_sel + SW'(1);
                end else if (ready) begin
                    w_cnt_nx = r_cnt + 3'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == S_BUSY);
        valid       = busy && req[r_sel];
        y           = valid && data_in[r_sel];
        last        = valid && (r_cnt == LAST_CNT);
        grant       = r_grant;
        sel         = r_sel;
        o_dbg_state = r_state;
        o_dbg_ptr   = r_ptr;
        o_dbg_cnt   = r_cnt;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the round-robin rules.
module tb_mux_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] data_in = '0;
    logic       ready = 1'b0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid, y, last, busy;
    logic       dbg_state;
    logic [2:0] dbg_ptr, dbg_cnt;

    int total = 0;
    int bad = 0;

    // Model: who owns the mux, how many beats it has been given, where the
    // next search starts.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_next;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.NREQ(8), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ready(ready),
        .grant(grant), .sel(sel), .valid(valid), .y(y), .last(last), .busy(busy),
        .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr), .o_dbg_cnt(dbg_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_next  = 0;
    endtask

    task automatic check_all();
        bit   e_valid;
        logic [7:0] e_grant;
        e_valid = m_busy && req[m_owner];
        e_grant = m_busy ? 8'(1 << m_owner) : 8'h00;
        check("grant", grant, e_grant);
        check("sel",   8'(sel), 8'(m_owner));
        check("busy",  8'(busy), 8'(m_busy));
        check("valid", 8'(valid), 8'(e_valid));
        check("y",     8'(y), 8'(e_valid && data_in[m_owner]));
        check("last",  8'(last), 8'(e_valid && (m_beats == BURST - 1)));
        check("ptr",   8'(dbg_ptr), 8'(m_next));
        check("cnt",   8'(dbg_cnt), 8'(m_beats));
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_next + k) % 8]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_next + k) % 8;
                    m_beats = 0;
                end
            end
        end else if (!req[m_owner] || (ready && m_beats == BURST - 1)) begin
            m_busy  = 1'b0;
            m_beats = 0;
            m_next  = (m_owner + 1) % 8;
        end else if (ready) begin
            m_beats++;
        end
    endtask

    // Called on a falling edge: drive, check, take the rising edge, return.
    task automatic cyc(input logic [7:0] r, input logic rdy);
        req     = r;
        ready   = rdy;
        data_in = 8'($urandom);
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        req   = '0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (2) cyc(8'h00, 1'b1);

        // Single requester 3, full burst, then the bubble.
        repeat (5) cyc(8'h08, 1'b1);
        check("ptr_after_burst", 8'(dbg_ptr), 8'd4);
        cyc(8'h00, 1'b1);

        // Asynchronous reset two beats into a burst.
        repeat (3) cyc(8'h08, 1'b1);
        check("cnt_before_reset", 8'(dbg_cnt), 8'd2);
        do_reset();
        repeat (2) cyc(8'h00, 1'b0);

        // Full rotation with every requester asserting.
        repeat (45) cyc(8'hFF, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);

        // Move ptr to 6, then wrap past 7 and skip requester 1.
        repeat (5) cyc(8'h20, 1'b1);
        check("ptr_six", 8'(dbg_ptr), 8'd6);
        cyc(8'h05, 1'b1);
        check("wrap_sel", 8'(sel), 8'd0);
        repeat (11) cyc(8'h05, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);

        // Backpressure on requester 5.
        repeat (11) cyc(8'h20, 1'b0);
        repeat (5) cyc(8'h20, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);

        // Requester 2 withdraws after one beat; 4 follows after a bubble.
        repeat (2) cyc(8'h14, 1'b1);
        repeat (6) cyc(8'h10, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);

        // Random traffic with sparse request toggles.
        r = '0;
        for (int n = 0; n < 400; n++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cyc(r, ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
